al_exception_commit_reader: RTL and testbench
=============================================

// Module: al_exception_commit_reader
// PURPOSE
//  Commit-side consumer of the active-list exception RAM. Each cycle it drives one read address per commit lane,
//  starting at the AL head. It scans the returned exception words and grants commit to the youngest-safe prefix of
//  ready instructions. On the oldest excepting instruction it stops commit and runs a trap-request/flush handshake
//  with the recovery logic. Sits between the active list head logic and the exception RAM read ports.
// PARAMETERS
//  COMMIT_WIDTH  4   commit lanes (1..4); lane k reads AL entry head+k
//  DEPTH         16  AL / exception RAM entries; must equal 2**INDEX
//  INDEX         4   AL index width
//  WIDTH         8   exception word width; bit0 = exception flag, bits[WIDTH-1:1] = cause
// PORTS
//  clk            in   1                   clock, all state on rising edge
//  reset          in   1                   asynchronous, active-low reset
//  headPtr_i      in   INDEX               current AL head index
//  commitReady_i  in   COMMIT_WIDTH        bit k: entry head+k has completed execution
//  rdAddr_o       out  COMMIT_WIDTH*INDEX  per-lane exception RAM read address (combinational)
//  rdData_i       in   COMMIT_WIDTH*WIDTH  per-lane exception word, same-cycle combinational read
//  commitMask_o   out  COMMIT_WIDTH        lanes permitted to commit this cycle (contiguous from lane 0)
//  trapReq_o      out  1                   trap request to recovery logic (registered)
//  trapAck_i      in   1                   recovery accepted the trap
//  flushDone_i    in   1                   pipeline flush complete
//  excptValid_o   out  1                   latched exception info valid
//  excptIndex_o   out  INDEX               AL index of the excepting instruction
//  excptCause_o   out  WIDTH-1             latched cause bits
//  excptCount_o   out  16                  saturating count of traps taken
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; trapReq_o, excptValid_o, excptIndex_o, excptCause_o and excptCount_o = 0.
//    commitMask_o evaluates to 0 while reset is asserted.
//  - rdAddr_o[k] = (headPtr_i + k) mod DEPTH. Wraps naturally in INDEX bits (e.g. head=14, k=3 -> addr 1).
//  - ready prefix P = the lanes 0..p-1 where commitReady_i[0..p-1] are all 1. Lanes after the first 0 are ignored,
//    including their exception flags.
//  - e = lowest lane in P with rdData_i[e][0]==1; if there is none, no exception is detected.
//  - commitMask_o (combinational): in IDLE = lanes of P below e (all of P if no exception); in any other state = 0.
//    The excepting instruction itself never commits.
//  - FSM: IDLE, TRAP_REQ, DRAIN.
//    IDLE: if an exception is detected, at the next edge go to TRAP_REQ and latch the following:
//      - excptIndex_o = head+e mod DEPTH
//      - excptCause_o = rdData_i[e][WIDTH-1:1]
//      - excptValid_o = 1
//      - excptCount_o += 1 (saturates at 16'hFFFF)
//    TRAP_REQ: trapReq_o = 1 (registered, asserted the cycle after detection).
//      - trapAck_i=1 and flushDone_i=0: go to DRAIN.
//      - trapAck_i=1 and flushDone_i=1: go directly to IDLE.
//      - trapAck_i=0: hold, with trapReq_o held high.
//    DRAIN: trapReq_o = 0. On flushDone_i=1 go to IDLE and clear excptValid_o. excptIndex_o and excptCause_o keep
//      their values until the next capture.
//  - trapAck_i and flushDone_i are ignored in IDLE. flushDone_i is ignored in TRAP_REQ unless trapAck_i is also 1.
//  - Latency: detection cycle N -> commitMask_o gated in cycle N; trapReq_o=1 in cycle N+1.
//  - Re-entry: back in IDLE, scanning resumes in that same cycle. A new exception re-latches the info.
//  - Reset mid-handshake: returns immediately to IDLE with all outputs cleared. No pending trap survives reset.
// TESTING
//  1 No exceptions, ready=4'b1111, head=5 -> rdAddr={8,7,6,5}, commitMask=4'b1111, trapReq stays 0.
//  2 head=14, ready=4'b1111, lane2 word=8'h0B -> rdAddr lane3=1, commitMask=4'b0011.
//    Next cycle: trapReq=1, excptIndex=0, excptCause=7'h05, excptCount=1.
//  3 ready=4'b1101, lane3 exception flag set -> ignored; commitMask=4'b0001, no trap.
//  4 Trap pending, trapAck held 0 for 3 cycles -> trapReq stays 1 and commitMask=0.
//    Ack then flushDone 2 cycles later -> DRAIN then IDLE; excptValid drops with flushDone.
//  5 trapAck and flushDone in the same cycle in TRAP_REQ -> IDLE next cycle; excptCount increments once only.
//  6 reset pulled low during DRAIN -> all outputs 0 asynchronously.
//    After release, a lane0 exception -> commitMask=0, trap sequence restarts, excptCount=1.

Source files
------------

// File: rtl/al_exception_commit_reader.sv
// Commit-side reader of the active-list exception RAM. Drives one read address per commit
// lane starting at the AL head, grants commit to the ready prefix up to (not including) the
// oldest excepting lane, and runs a trap-request / flush handshake with recovery logic.
module al_exception_commit_reader #(
  parameter int unsigned COMMIT_WIDTH = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned INDEX        = 4,
  parameter int unsigned WIDTH        = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INDEX-1:0]              headPtr_i,
  input  logic [COMMIT_WIDTH-1:0]       commitReady_i,
  output logic [COMMIT_WIDTH*INDEX-1:0] rdAddr_o,
  input  logic [COMMIT_WIDTH*WIDTH-1:0] rdData_i,
  output logic [COMMIT_WIDTH-1:0]       commitMask_o,
  output logic                          trapReq_o,
  input  logic                          trapAck_i,
  input  logic                          flushDone_i,
  output logic                          excptValid_o,
  output logic [INDEX-1:0]              excptIndex_o,
  output logic [WIDTH-2:0]              excptCause_o,
  output logic [15:0]                   excptCount_o
);

  typedef enum logic [1:0] {StIdle, StTrapReq, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    trap_req_q;
  logic                    valid_q;
  logic [INDEX-1:0]        index_q;
  logic [WIDTH-2:0]        cause_q;
  logic [15:0]             count_q;

  logic [COMMIT_WIDTH-1:0] scan_mask;
  logic                    exc_found;
  logic [INDEX-1:0]        exc_index;
  logic [WIDTH-2:0]        exc_cause;
  logic                    capture;
  logic                    clear_valid;

  // Per-lane read address: head + lane, wrapping around the AL.
  always_comb begin
    rdAddr_o = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      rdAddr_o[k*INDEX +: INDEX] = INDEX'((32'(headPtr_i) + 32'(k)) % DEPTH);
    end
  end

  // Walk the ready prefix; stop at the first not-ready lane or the oldest exception.
  always_comb begin
    scan_mask = '0;
    exc_found = 1'b0;
    exc_index = '0;
    exc_cause = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (!exc_found && (scan_mask == ((COMMIT_WIDTH)'(1) << k) - 1'b1) && commitReady_i[k]) begin
        if (rdData_i[k*WIDTH]) begin
          exc_found = 1'b1;
          exc_index = rdAddr_o[k*INDEX +: INDEX];
          exc_cause = rdData_i[k*WIDTH+1 +: WIDTH-1];
        end else begin
          scan_mask[k] = 1'b1;
        end
      end
    end
  end

  // Commit is only granted while idle and out of reset.
  assign commitMask_o = (reset && (state_q == StIdle)) ? scan_mask : '0;

  // Handshake next-state.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    clear_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (exc_found) begin
          state_d = StTrapReq;
          capture = 1'b1;
        end
      end
      StTrapReq: begin
        if (trapAck_i) begin
          if (flushDone_i) begin
            state_d     = StIdle;
            clear_valid = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (flushDone_i) begin
          state_d     = StIdle;
          clear_valid = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, registered trap request and latched exception info.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      trap_req_q <= 1'b0;
      valid_q    <= 1'b0;
      index_q    <= '0;
      cause_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      trap_req_q <= (state_d == StTrapReq);
      if (capture) begin
        valid_q <= 1'b1;
        index_q <= exc_index;
        cause_q <= exc_cause;
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
      end else if (clear_valid) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign trapReq_o    = trap_req_q;
  assign excptValid_o = valid_q;
  assign excptIndex_o = index_q;
  assign excptCause_o = cause_q;
  assign excptCount_o = count_q;

endmodule

// File: tb/tb_al_exception_commit_reader.sv
// Self-checking bench for al_exception_commit_reader: directed scenarios then random traffic,
// compared against a behavioural model of the commit/trap rules.
module tb_al_exception_commit_reader;

  localparam int CW = 4;
  localparam int IW = 4;
  localparam int WW = 8;
  localparam int DP = 16;

  logic              clk;
  logic              reset;
  logic [IW-1:0]     head_ptr;
  logic [CW-1:0]     commit_ready;
  logic [CW*IW-1:0]  rd_addr;
  logic [CW*WW-1:0]  rd_data;
  logic [CW-1:0]     commit_mask;
  logic              trap_req;
  logic              trap_ack;
  logic              flush_done;
  logic              excpt_valid;
  logic [IW-1:0]     excpt_index;
  logic [WW-2:0]     excpt_cause;
  logic [15:0]       excpt_count;

  logic [WW-1:0]     ram [DP];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending request, draining, latched info.
  bit m_req, m_drain, m_valid;
  int m_index, m_cause, m_count;

  al_exception_commit_reader #(
    .COMMIT_WIDTH(CW), .DEPTH(DP), .INDEX(IW), .WIDTH(WW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .headPtr_i    (head_ptr),
    .commitReady_i(commit_ready),
    .rdAddr_o     (rd_addr),
    .rdData_i     (rd_data),
    .commitMask_o (commit_mask),
    .trapReq_o    (trap_req),
    .trapAck_i    (trap_ack),
    .flushDone_i  (flush_done),
    .excptValid_o (excpt_valid),
    .excptIndex_o (excpt_index),
    .excptCause_o (excpt_cause),
    .excptCount_o (excpt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exception RAM: combinational read on the DUT's addresses.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < CW; k++) begin
      rd_data[k*WW +: WW] = ram[rd_addr[k*IW +: IW]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ram();
    for (int a = 0; a < DP; a++) ram[a] = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":trap_req"},     32'(trap_req),    32'(m_req));
    chk({tag, ":excpt_valid"},  32'(excpt_valid), 32'(m_valid));
    chk({tag, ":excpt_index"},  32'(excpt_index), m_index);
    chk({tag, ":excpt_cause"},  32'(excpt_cause), m_cause);
    chk({tag, ":excpt_count"},  32'(excpt_count), m_count);
  endtask

  // One clock: apply inputs, check combinational outputs, advance model, check registers.
  task automatic step(input string tag, input logic [3:0] hd, input logic [3:0] rdy,
                      input logic ak, input logic fd);
    logic [3:0] em;
    bit         found;
    int         e;
    bit         idle;
    head_ptr     = hd;
    commit_ready = rdy;
    trap_ack     = ak;
    flush_done   = fd;
    #1;
    em = '0; found = 0; e = 0;
    for (int k = 0; k < CW; k++) begin
      if (!rdy[k]) break;
      if (ram[(int'(hd) + k) % DP][0]) begin
        found = 1; e = k;
        break;
      end
      em[k] = 1'b1;
    end
    idle = !m_req && !m_drain;
    for (int k = 0; k < CW; k++) begin
      chk($sformatf("%s:rd_addr%0d", tag, k), 32'(rd_addr[k*IW +: IW]), (int'(hd) + k) % DP);
    end
    chk({tag, ":commit_mask"}, 32'(commit_mask), idle ? 32'(em) : 32'd0);
    if (idle) begin
      if (found) begin
        m_req   = 1;
        m_valid = 1;
        m_index = (int'(hd) + e) % DP;
        m_cause = int'(ram[m_index]) >> 1;
        if (m_count < 16'hFFFF) m_count++;
      end
    end else if (m_req) begin
      if (ak) begin
        m_req = 0;
        if (fd) m_valid = 0;
        else    m_drain = 1;
      end
    end else if (fd) begin
      m_drain = 0;
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    m_req = 0; m_drain = 0; m_valid = 0;
    m_index = 0; m_cause = 0; m_count = 0;
  endtask

  initial begin
    reset        = 1'b0;
    head_ptr     = '0;
    commit_ready = 4'hF;
    trap_ack     = 1'b0;
    flush_done   = 1'b0;
    clear_ram();
    model_reset();
    #2;
    // Reset state: registers cleared and mask forced low despite a committable prefix.
    check_regs("reset");
    chk("reset:commit_mask", 32'(commit_mask), 32'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // No exceptions, full prefix.
    step("t1", 4'd5, 4'b1111, 1'b0, 1'b0);

    // Wrapping addresses, exception in lane 2 (entry 0).
    clear_ram();
    ram[0] = 8'h0B;
    step("t2", 4'd14, 4'b1111, 1'b0, 1'b0);

    // Hold the request without ack, then ack, drain, flush.
    step("t4_hold0", 4'd14, 4'b1111, 1'b0, 1'b1);
    step("t4_hold1", 4'd14, 4'b1111, 1'b0, 1'b0);
    step("t4_hold2", 4'd14, 4'b1111, 1'b0, 1'b0);
    step("t4_ack",   4'd14, 4'b1111, 1'b1, 1'b0);
    step("t4_drain", 4'd14, 4'b0000, 1'b0, 1'b0);
    step("t4_flush", 4'd14, 4'b0000, 1'b0, 1'b1);

    // Exception beyond the ready prefix is ignored.
    clear_ram();
    ram[3] = 8'h21;
    step("t3", 4'd0, 4'b1101, 1'b1, 1'b1);

    // Ack and flush together: straight back to idle, one count.
    clear_ram();
    ram[9] = 8'hFF;
    step("t5_det", 4'd9, 4'b0001, 1'b0, 1'b0);
    clear_ram();
    step("t5_ackflush", 4'd9, 4'b1111, 1'b1, 1'b1);
    step("t5_idle", 4'd9, 4'b1111, 1'b1, 1'b1);

    // Reset asserted during drain clears everything asynchronously.
    ram[4] = 8'h13;
    step("t6_det", 4'd4, 4'b0001, 1'b0, 1'b0);
    step("t6_ack", 4'd4, 4'b0000, 1'b1, 1'b0);
    head_ptr     = 4'd4;
    commit_ready = 4'b1110;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_regs("t6_async");
    chk("t6_async:commit_mask", 32'(commit_mask), 32'd0);
    commit_ready = 4'b0000;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("t6_lane0", 4'd4, 4'b1111, 1'b0, 1'b0);
    step("t6_ack2",  4'd4, 4'b1111, 1'b1, 1'b0);
    step("t6_done",  4'd4, 4'b1111, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rdy;
      for (int a = 0; a < DP; a++) begin
        ram[a] = {7'($urandom), ($urandom_range(3) == 0)};
      end
      rdy = ($urandom_range(1) == 1) ? 4'hF : 4'($urandom);
      step("rand", 4'($urandom), rdy, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
